// File: rtl/aurora_axi_tx_combiner.sv
// aurora_axi_tx_combiner
// Sums CH_COUNT AXI-Stream channels lane by lane into one AXI-Stream output.
// Each output lane is the signed per-lane sum of the unmasked channels. That sum
// is arithmetically right-shifted and then saturated to SAMPLE_W bits.
// Three-stage pipeline driven by one enable (adv_s). The output register is the
// last stage, so a stalled output freezes the whole pipe.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   shift            right-shift for the sum, clamped to clog2(CH_COUNT)
//   eth_mask         per-channel exclude (1 = ignored for data and handshake)
//   axis_s_*         CH_COUNT input streams, packed channel-major
//   axis_m_*         combined output stream
//   sat_flag         sticky: an output lane saturated since reset
//   tlast_err        sticky: unmasked channels disagreed on tlast in an accepted beat
module aurora_axi_tx_combiner #(
  parameter int CH_COUNT = 4,
  parameter int SAMPLE_W = 16,
  parameter int LANES    = 2,
  parameter int SIM      = 0
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [3:0]                          shift,
  input  logic [CH_COUNT-1:0]                 eth_mask,
  output logic [CH_COUNT-1:0]                 axis_s_tready,
  input  logic [CH_COUNT*LANES*SAMPLE_W-1:0]  axis_s_tdata,
  input  logic [CH_COUNT*LANES*SAMPLE_W/8-1:0] axis_s_tkeep,
  input  logic [CH_COUNT-1:0]                 axis_s_tvalid,
  input  logic [CH_COUNT-1:0]                 axis_s_tlast,
  input  logic                                axis_m_tready,
  output logic [LANES*SAMPLE_W-1:0]           axis_m_tdata,
  output logic [LANES*SAMPLE_W/8-1:0]         axis_m_tkeep,
  output logic                                axis_m_tvalid,
  output logic                                axis_m_tlast,
  output logic                                sat_flag,
  output logic                                tlast_err
);

  localparam int DW = LANES * SAMPLE_W;
  localparam int KW = DW / 8;
  localparam int SW = $clog2(CH_COUNT);
  localparam int AW = SAMPLE_W + SW;  // sum width: cannot overflow for CH_COUNT addends
  localparam logic [3:0] SW_MAX = 4'(SW);
  localparam logic signed [AW-1:0] SMAX = {{(SW + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  // Saturate a shifted sum to SAMPLE_W bits.
  function automatic logic [SAMPLE_W-1:0] sat_lane(input logic signed [AW-1:0] v);
    if (v > SMAX) begin
      return SMAX[SAMPLE_W-1:0];
    end else if (v < SMIN) begin
      return SMIN[SAMPLE_W-1:0];
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

  // True when a shifted sum falls outside the SAMPLE_W range.
  function automatic logic is_sat(input logic signed [AW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  logic                    adv_s;
  logic                    all_ok_s;
  logic                    accept_s;
  logic                    last_and_s;
  logic                    last_or_s;
  logic [3:0]              shift_clamp_s;
  logic [CH_COUNT*DW-1:0]  masked_data_s;
  logic [LANES*AW-1:0]     sum_s;
  logic signed [AW-1:0]    shifted_s [LANES];
  logic [DW-1:0]           lane_out_s;
  logic                    lane_sat_s;
  logic                    unused_s;

  logic                    v0_r;
  logic [CH_COUNT*DW-1:0]  data0_r;
  logic [3:0]              shift0_r;
  logic                    last0_r;
  logic                    v1_r;
  logic [LANES*AW-1:0]     sum1_r;
  logic [3:0]              shift1_r;
  logic                    last1_r;

  // Byte enables are not used; SIM has no functional effect.
  assign unused_s = ^{axis_s_tkeep, 1'(SIM)};

  // Handshake: masked channels count as valid; the all-masked case never accepts.
  assign adv_s         = !axis_m_tvalid || axis_m_tready;
  assign all_ok_s      = (&(axis_s_tvalid | eth_mask)) && !(&eth_mask);
  assign accept_s      = all_ok_s && adv_s && rstn;
  assign axis_s_tready = {CH_COUNT{accept_s}};
  assign last_and_s    = &(axis_s_tlast | eth_mask);
  assign last_or_s     = |(axis_s_tlast & ~eth_mask);
  assign shift_clamp_s = (shift > SW_MAX) ? SW_MAX : shift;

  // Zero the data of masked channels so they drop out of the sum.
  always_comb begin
    masked_data_s = '0;
    for (int x = 0; x < CH_COUNT; x++) begin
      masked_data_s[x*DW +: DW] = eth_mask[x] ? {DW{1'b0}} : axis_s_tdata[x*DW +: DW];
    end
  end

  // Stage 0: capture the accepted beat together with its shift and tlast.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v0_r     <= 1'b0;
      data0_r  <= '0;
      shift0_r <= 4'd0;
      last0_r  <= 1'b0;
    end else if (adv_s) begin
      v0_r <= accept_s;
      if (accept_s) begin
        data0_r  <= masked_data_s;
        shift0_r <= shift_clamp_s;
        last0_r  <= last_and_s;
      end
    end
  end

  // Sticky tlast disagreement: some unmasked channels had tlast set and some did not.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tlast_err <= 1'b0;
    end else if (accept_s && last_or_s && !last_and_s) begin
      tlast_err <= 1'b1;
    end
  end

  // Sign-extend each sample to AW bits and add across channels, per lane.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int x = 0; x < CH_COUNT; x++) begin
        sum_s[k*AW +: AW] = sum_s[k*AW +: AW] +
          {{SW{data0_r[x*DW + k*SAMPLE_W + SAMPLE_W - 1]}}, data0_r[x*DW + k*SAMPLE_W +: SAMPLE_W]};
      end
    end
  end

  // Stage 1: register the full-width sums.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_r     <= 1'b0;
      sum1_r   <= '0;
      shift1_r <= 4'd0;
      last1_r  <= 1'b0;
    end else if (adv_s) begin
      v1_r <= v0_r;
      if (v0_r) begin
        sum1_r   <= sum_s;
        shift1_r <= shift0_r;
        last1_r  <= last0_r;
      end
    end
  end

  // Arithmetic shift and saturation for each lane.
  always_comb begin
    lane_out_s = '0;
    lane_sat_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      shifted_s[k] = $signed(sum1_r[k*AW +: AW]) >>> shift1_r;
      lane_out_s[k*SAMPLE_W +: SAMPLE_W] = sat_lane(shifted_s[k]);
      lane_sat_s = lane_sat_s | is_sat(shifted_s[k]);
    end
  end

  // Stage 2: output register. Holding it while stalled keeps tdata/tlast stable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      axis_m_tvalid <= 1'b0;
      axis_m_tkeep  <= '0;
      axis_m_tdata  <= '0;
      axis_m_tlast  <= 1'b0;
      sat_flag      <= 1'b0;
    end else if (adv_s) begin
      axis_m_tvalid <= v1_r;
      axis_m_tkeep  <= v1_r ? {KW{1'b1}} : {KW{1'b0}};
      if (v1_r) begin
        axis_m_tdata <= lane_out_s;
        axis_m_tlast <= last1_r;
        sat_flag     <= sat_flag | lane_sat_s;
      end
    end
  end

endmodule

// File: tb/tb_aurora_axi_tx_combiner.sv
// Directed self-checking bench for aurora_axi_tx_combiner (CH_COUNT=4, SAMPLE_W=16, LANES=2).
module tb_aurora_axi_tx_combiner;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   shift;
  logic [3:0]   eth_mask;
  logic [3:0]   s_tready;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tlast;
  logic         m_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         sat_flag;
  logic         tlast_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aurora_axi_tx_combiner #(.CH_COUNT(4), .SAMPLE_W(16), .LANES(2), .SIM(0)) dut (
    .clk(clk), .rstn(rstn), .shift(shift), .eth_mask(eth_mask),
    .axis_s_tready(s_tready), .axis_s_tdata(s_tdata), .axis_s_tkeep(s_tkeep),
    .axis_s_tvalid(s_tvalid), .axis_s_tlast(s_tlast),
    .axis_m_tready(m_tready), .axis_m_tdata(m_tdata), .axis_m_tkeep(m_tkeep),
    .axis_m_tvalid(m_tvalid), .axis_m_tlast(m_tlast),
    .sat_flag(sat_flag), .tlast_err(tlast_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    s_tvalid = 4'h0;
    s_tlast  = 4'h0;
    s_tdata  = 128'h0;
  endtask

  task automatic set_lane(input int x, input int k, input logic [15:0] v);
    s_tdata[x*32 + k*16 +: 16] = v;
  endtask

  // Inputs already driven; checks accept, exact 3-cycle latency, and the following bubble.
  task automatic run_beat(input string tag, input logic [31:0] exp_data, input logic exp_last);
    #1;
    chk({tag, "_tready"}, 32'(s_tready), 32'h0000000F);
    tick();
    s_tvalid = 4'h0;
    chk({tag, "_lat1"}, 32'(m_tvalid), 32'h0);
    tick();
    chk({tag, "_lat2"}, 32'(m_tvalid), 32'h0);
    tick();
    chk({tag, "_lat3_valid"}, 32'(m_tvalid), 32'h1);
    chk({tag, "_data"}, m_tdata, exp_data);
    chk({tag, "_tkeep"}, 32'(m_tkeep), 32'h0000000F);
    chk({tag, "_tlast"}, 32'(m_tlast), 32'(exp_last));
    tick();
    chk({tag, "_after_valid"}, 32'(m_tvalid), 32'h0);
    chk({tag, "_after_tkeep"}, 32'(m_tkeep), 32'h0);
  endtask

  initial begin
    int in_idx;
    int out_idx;
    int seen;
    int first;
    logic stall_prev;
    logic [31:0] held;
    logic [31:0] got;

    rstn     = 1'b0;
    clear_in();
    s_tkeep  = 16'hFFFF;
    s_tvalid = 4'hF;
    eth_mask = 4'h0;
    shift    = 4'd0;
    m_tready = 1'b1;

    // Reset state, with inputs offering data that must not be taken.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_tkeep", 32'(m_tkeep), 32'h0);
    chk("rst_tdata", m_tdata, 32'h0);
    chk("rst_tlast", 32'(m_tlast), 32'h0);
    chk("rst_sat", 32'(sat_flag), 32'h0);
    chk("rst_tlast_err", 32'(tlast_err), 32'h0);
    chk("rst_tready", 32'(s_tready), 32'h0);
    s_tvalid = 4'h0;
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Basic sum: lane0 1000>>>2 = 250, lane1 10>>>2 = 2.
    set_lane(0, 0, 16'd100); set_lane(1, 0, 16'd200);
    set_lane(2, 0, 16'd300); set_lane(3, 0, 16'd400);
    set_lane(0, 1, 16'd1);   set_lane(1, 1, 16'd2);
    set_lane(2, 1, 16'd3);   set_lane(3, 1, 16'd4);
    s_tvalid = 4'hF;
    s_tlast  = 4'hF;
    shift    = 4'd2;
    run_beat("basic", 32'h000200FA, 1'b1);
    chk("basic_sat", 32'(sat_flag), 32'h0);
    chk("basic_tlast_err", 32'(tlast_err), 32'h0);

    // Positive saturation.
    clear_in();
    for (int x = 0; x < 4; x++) set_lane(x, 0, 16'h7FFF);
    s_tvalid = 4'hF;
    shift    = 4'd0;
    run_beat("sat_pos", 32'h00007FFF, 1'b0);
    chk("sat_pos_flag", 32'(sat_flag), 32'h1);

    // Negative saturation: the sum is exactly the 18-bit minimum.
    clear_in();
    for (int x = 0; x < 4; x++) set_lane(x, 0, 16'h8000);
    s_tvalid = 4'hF;
    run_beat("sat_neg", 32'h00008000, 1'b0);

    // A shift above clog2(4) clamps to 2: 0x1FFFC >>> 2 = 0x7FFF.
    clear_in();
    for (int x = 0; x < 4; x++) set_lane(x, 0, 16'h7FFF);
    s_tvalid = 4'hF;
    shift    = 4'd15;
    run_beat("shift_clamp", 32'h00007FFF, 1'b0);

    // Masked channels are idle and carry garbage; 10 + (-4) = 6.
    clear_in();
    shift    = 4'd0;
    eth_mask = 4'b1010;
    set_lane(0, 0, 16'd10);  set_lane(1, 0, 16'h03E8);
    set_lane(2, 0, 16'hFFFC); set_lane(3, 0, 16'h03E8);
    s_tvalid = 4'b0101;
    s_tlast  = 4'b0101;
    run_beat("mask", 32'h00000006, 1'b1);
    chk("mask_tlast_err", 32'(tlast_err), 32'h0);

    // All channels masked: no ready and no beats.
    clear_in();
    eth_mask = 4'hF;
    s_tvalid = 4'hF;
    #1;
    chk("allmask_tready", 32'(s_tready), 32'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_tvalid) seen++;
    end
    chk("allmask_beats", 32'(seen), 32'h0);
    clear_in();
    eth_mask = 4'h0;

    // tlast disagreement between unmasked channels.
    s_tvalid = 4'hF;
    s_tlast  = 4'b0001;
    run_beat("tlast", 32'h00000000, 1'b0);
    chk("tlast_err_set", 32'(tlast_err), 32'h1);

    // Backpressure: 8 beats, output stalled in cycles 4..9.
    clear_in();
    in_idx = 0;
    out_idx = 0;
    stall_prev = 1'b0;
    held = 32'h0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (in_idx < 8) begin
        s_tvalid = 4'hF;
        set_lane(0, 0, 16'(in_idx + 1));
      end else begin
        s_tvalid = 4'h0;
      end
      m_tready = !(c >= 4 && c <= 9);
      #1;
      if (stall_prev) begin
        chk("bp_stall_valid", 32'(m_tvalid), 32'h1);
        chk("bp_stall_data", m_tdata, held);
      end
      if (s_tready[0]) in_idx++;
      if (m_tvalid && m_tready) begin
        if (out_idx < 8) chk("bp_order", m_tdata, 32'(out_idx + 1));
        else chk("bp_extra_beat", 32'(out_idx), 32'd7);
        out_idx++;
      end
      stall_prev = m_tvalid && !m_tready;
      held = m_tdata;
    end
    chk("bp_in_count", 32'(in_idx), 32'd8);
    chk("bp_out_count", 32'(out_idx), 32'd8);
    m_tready = 1'b1;

    // Reset with three beats in flight.
    tick();
    clear_in();
    set_lane(0, 0, 16'h0011);
    s_tvalid = 4'hF;
    tick(); tick(); tick();
    chk("rst_pre_valid", 32'(m_tvalid), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_mid_tkeep", 32'(m_tkeep), 32'h0);
    chk("rst_mid_tdata", m_tdata, 32'h0);
    chk("rst_mid_sat", 32'(sat_flag), 32'h0);
    chk("rst_mid_tlast_err", 32'(tlast_err), 32'h0);
    chk("rst_mid_tready", 32'(s_tready), 32'h0);
    repeat (2) tick();
    clear_in();
    set_lane(0, 0, 16'h004D);
    s_tvalid = 4'hF;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_rel_tready", 32'(s_tready), 32'h0000000F);
    tick();
    s_tvalid = 4'h0;
    seen = 0;
    first = 0;
    got = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      if (m_tvalid) begin
        seen++;
        if (seen == 1) begin
          first = i;
          got = m_tdata;
        end
      end
      tick();
    end
    chk("rst_rel_beats", 32'(seen), 32'd1);
    chk("rst_rel_latency", 32'(first), 32'd3);
    chk("rst_rel_data", got, 32'h0000004D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aurora_axi_tx_combiner.md
AURORA_AXI_TX_COMBINER -- requirements
Module: aurora_axi_tx_combiner

Interface
REQ-001 Parameter CH_COUNT, default 4, number of input AXI-Stream channels; legal 2..8.
REQ-002 Parameter SAMPLE_W, default 16, signed sample width; legal 8..16.
REQ-003 Parameter LANES, default 2, samples per beat; data width DW = LANES*SAMPLE_W.
REQ-004 Parameter SIM, default 0, no functional effect.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 shift  in  4  arithmetic right-shift applied to the sum; values above SW = clog2(CH_COUNT) clamp to SW.
REQ-008 eth_mask  in  CH_COUNT  1 = channel excluded from the sum and from the handshake; 0 = normal work.
REQ-009 axis_s_tready  out  CH_COUNT  per-channel ready.
REQ-010 axis_s_tdata  in  CH_COUNT*DW  channel x at bits [x*DW +: DW]; lane k at [k*SAMPLE_W +: SAMPLE_W].
REQ-011 axis_s_tkeep  in  CH_COUNT*DW/8  ignored.
REQ-012 axis_s_tvalid, axis_s_tlast  in  CH_COUNT each.
REQ-013 axis_m_tready  in  1; axis_m_tdata  out  DW; axis_m_tkeep  out  DW/8; axis_m_tvalid  out  1; axis_m_tlast  out  1.
REQ-014 sat_flag  out  1  sticky: any output lane saturated since reset.
REQ-015 tlast_err  out  1  sticky: unmasked channels disagreed on tlast in an accepted beat.

Function
REQ-016 adv = !axis_m_tvalid_stage2_occupied | axis_m_tready; a single pipeline enable; no stage moves when adv = 0.
REQ-017 all_ok = AND over x of (axis_s_tvalid[x] | eth_mask[x]) and at least one channel unmasked.
REQ-018 accept = all_ok & adv; every bit of axis_s_tready = accept (masked channels drained in lockstep, data discarded).
REQ-019 All-channels-masked: accept = 0, tready = 0, no output beats.
REQ-020 Pipeline: stage0 registers masked data (masked channel forced to 0), clamped shift, tlast; stage1 computes per-lane signed sum, width SAMPLE_W+SW, no overflow; stage2 shifts arithmetically and saturates to SAMPLE_W into axis_m_tdata.
REQ-021 Latency: accept in cycle N -> axis_m_tvalid = 1 in cycle N+3 when adv stays 1; throughput one beat per cycle.
REQ-022 Each stage carries a valid bit; bubbles do not produce output beats; with adv = 0 all stages hold, no data loss or duplication.
REQ-023 Saturation: shifted value > 2^(SAMPLE_W-1)-1 -> max positive; < -2^(SAMPLE_W-1) -> min negative; sets sat_flag.
REQ-024 axis_m_tlast = AND of unmasked tlast of the beat; tlast_err set if unmasked tlast bits differ at accept.
REQ-025 eth_mask and shift are sampled at accept only; changes affect the next accepted beat, never beats in flight.
REQ-026 axis_m_tkeep = all ones whenever axis_m_tvalid = 1, else 0.
REQ-027 axis_m_tdata/tlast stable while axis_m_tvalid = 1 and axis_m_tready = 0.

Reset
REQ-028 rstn = 0 asynchronously clears all stage valids, axis_m_tvalid, axis_m_tlast, axis_m_tdata, axis_m_tkeep, sat_flag, tlast_err to 0; axis_s_tready = 0 while rstn = 0.
REQ-029 Reset mid-packet discards all in-flight beats; first accept possible on the first clk edge after rstn rises.

Verification
REQ-030 CH_COUNT=4, mask 0, shift 2, lane0 inputs 100,200,300,400, tready=1 -> 3 cycles later lane0 = 250, tkeep = 0xF.
REQ-031 Saturation: 4 channels lane0 = 0x7FFF, shift 0 -> lane0 = 0x7FFF, sat_flag = 1; all 0x8000 -> 0x8000.
REQ-032 Mask 4'b1010, ch1/ch3 tvalid = 0, ch0 = 10, ch2 = -4, shift 0 -> accept occurs, output 6; mask 4'hF -> tready = 0, no beats.
REQ-033 Backpressure: stream 8 beats, axis_m_tready = 0 for cycles 4-9 -> all 8 beats out in order, none lost or duplicated, data stable while stalled.
REQ-034 tlast: ch0 tlast = 1, ch1 tlast = 0, both unmasked -> axis_m_tlast = 0, tlast_err = 1.
REQ-035 Assert rstn = 0 with 3 beats in flight -> tvalid drops immediately, no stale beat after release.
